// File: rtl/sh7604_arb_pkg.sv
// Shared types and helpers for the SH7604 DBUS arbiter family.
// The round-robin search is kept here so wider variants can reuse it.
package sh7604_arb_pkg;

    localparam int NUM_MASTERS = 3;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    // First pending master found scanning upward from last+1 (wrapping),
    // or OWN_NONE. A last of OWN_NONE starts the scan at master 0.
    function automatic owner_t next_rr(input logic [2:0] pending, input owner_t last);
        owner_t idx;
        owner_t res;
        res = OWN_NONE;
        idx = (last >= 2'd2) ? 2'd0 : last + 2'd1;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if ((res == OWN_NONE) && pending[idx]) begin
                res = idx;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sh7604_dbus_arb_if.sv
// Master-side and slave-side DBUS signals of the arbiter, one bundle.
// Handshake: a master raises m_req with its address/data/lanes and holds
// them until it samples its own m_busy=0 on a CE_R edge; that edge is the
// completion. The slave port follows the same rule with s_req/s_busy.
interface sh7604_dbus_arb_if;
    import sh7604_arb_pkg::*;

    logic [31:0]            m_a    [NUM_MASTERS];
    logic [31:0]            m_do   [NUM_MASTERS];
    logic [31:0]            m_di   [NUM_MASTERS];
    logic [3:0]             m_ba   [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] m_we;
    logic [NUM_MASTERS-1:0] m_req;
    logic [NUM_MASTERS-1:0] m_lock;
    logic [NUM_MASTERS-1:0] m_busy;
    logic [NUM_MASTERS-1:0] m_gnt;

    logic [31:0] s_a;
    logic [31:0] s_do;
    logic [31:0] s_di;
    logic [3:0]  s_ba;
    logic        s_we;
    logic        s_req;
    logic        s_lock;
    logic        s_busy;

    // Arbiter view.
    modport slave (
        input  m_a, m_do, m_ba, m_we, m_req, m_lock, s_di, s_busy,
        output m_di, m_busy, m_gnt, s_a, s_do, s_ba, s_we, s_req, s_lock
    );

    // Environment view: the requesting masters and the target.
    modport master (
        output m_a, m_do, m_ba, m_we, m_req, m_lock, s_di, s_busy,
        input  m_di, m_busy, m_gnt, s_a, s_do, s_ba, s_we, s_req, s_lock
    );

endinterface

// File: rtl/sh7604_arb_pick.sv
// Combinational winner select: fixed priority (lowest index) or
// round-robin starting after the last owner.
module sh7604_arb_pick
    import sh7604_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   rr_en,
    input  owner_t                 last,
    output logic                   valid,
    output owner_t                 winner
);

    always_comb begin
        winner = OWN_NONE;
        if (rr_en) begin
            winner = next_rr(req, last);
        end else if (req[0]) begin
            winner = 2'd0;
        end else if (req[1]) begin
            winner = 2'd1;
        end else if (req[2]) begin
            winner = 2'd2;
        end
        valid = (winner != OWN_NONE);
    end

endmodule

// File: rtl/sh7604_dbus_arb.sv
// SH7604 DBUS arbiter: CPU cache side and two DMA channels share one
// slave port, with fixed/round-robin priority and a bounded bus lock.
module sh7604_dbus_arb
    import sh7604_arb_pkg::*;
#(
    parameter int     MAX_LOCK  = 0,
    parameter owner_t RST_OWNER = 2'd0
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CE_R,
    input  logic               RR_EN,
    sh7604_dbus_arb_if.slave   bus,
    output owner_t             OWNER,
    output arb_state_e         STATE
);

    localparam int CW = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_MAX = (MAX_LOCK < 1) ? '1 : CW'(MAX_LOCK);

    arb_state_e state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     ptr_q, ptr_d;
    logic [CW-1:0] lcnt_q, lcnt_d;

    logic                   own_req, own_lock;
    logic [NUM_MASTERS-1:0] own_mask, others, pick_req;
    logic                   complete, lock_full, forced, arb;
    logic                   win_valid;
    owner_t                 win;

    always_comb begin
        own_req  = 1'b0;
        own_lock = 1'b0;
        own_mask = '0;
        if (state_q == ST_OWNED) begin
            own_req           = bus.m_req[owner_q];
            own_lock          = bus.m_lock[owner_q];
            own_mask[owner_q] = 1'b1;
        end
        others    = bus.m_req & ~own_mask;
        complete  = CE_R && (state_q == ST_OWNED) && own_req && !bus.s_busy;
        lock_full = (MAX_LOCK != 0) && ((int'(lcnt_q) + 1) >= MAX_LOCK);
        forced    = complete && own_lock && lock_full && (|others);
        arb       = CE_R && ((state_q == ST_IDLE) ||
                             (complete && !own_lock) ||
                             forced ||
                             ((state_q == ST_OWNED) && !own_req && !own_lock));
        // A forced release must hand the bus to someone else.
        pick_req  = forced ? others : bus.m_req;
    end

    sh7604_arb_pick u_pick (
        .req    (pick_req),
        .rr_en  (RR_EN),
        .last   (ptr_q),
        .valid  (win_valid),
        .winner (win)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        lcnt_d  = lcnt_q;
        if (arb) begin
            lcnt_d = '0;
            if (win_valid) begin
                state_d = ST_OWNED;
                owner_d = win;
                ptr_d   = win;
            end else begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        end else if (complete && (lcnt_q != CNT_MAX)) begin
            // Only locked completions reach here; unlocked ones arbitrate.
            lcnt_d = lcnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            ptr_q   <= RST_OWNER;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            lcnt_q  <= lcnt_d;
        end
    end

    always_comb begin
        logic g;
        bus.s_a    = '0;
        bus.s_do   = '0;
        bus.s_ba   = '0;
        bus.s_we   = 1'b0;
        bus.s_req  = 1'b0;
        bus.s_lock = 1'b0;
        if (state_q == ST_OWNED) begin
            bus.s_a    = bus.m_a[owner_q];
            bus.s_do   = bus.m_do[owner_q];
            bus.s_ba   = bus.m_ba[owner_q];
            bus.s_we   = bus.m_we[owner_q];
            bus.s_req  = bus.m_req[owner_q];
            bus.s_lock = bus.m_lock[owner_q];
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            g              = (state_q == ST_OWNED) && (owner_q == owner_t'(i));
            bus.m_di[i]    = bus.s_di;
            bus.m_gnt[i]   = g;
            bus.m_busy[i]  = g ? bus.s_busy : bus.m_req[i];
        end
    end

    assign OWNER = owner_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_sh7604_dbus_arb.sv
// Directed bench for sh7604_dbus_arb: a vector table covering priority,
// lock and lock-limit behaviour, plus wait-state and reset sequences.
module tb_sh7604_dbus_arb;
    import sh7604_arb_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce_r  = 1'b1;
    logic       rr_en = 1'b0;
    owner_t     owner;
    arb_state_e state;

    sh7604_dbus_arb_if bus ();

    sh7604_dbus_arb #(
        .MAX_LOCK  (4),
        .RST_OWNER (2'd2)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .CE_R  (ce_r),
        .RR_EN (rr_en),
        .bus   (bus),
        .OWNER (owner),
        .STATE (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] req;
        logic [2:0] lock;
        logic       sb;
        logic       rr;
        logic       ce;
        owner_t     own;
        logic [2:0] busy;
        logic       sreq;
        logic       slock;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    logic [31:0] a_tab  [3] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
    logic [31:0] do_tab [3] = '{32'hAAAA_0000, 32'hBBBB_1111, 32'hCCCC_2222};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] req, input logic [2:0] lock, input logic sb);
        bus.m_req  = req;
        bus.m_lock = lock;
        bus.s_busy = sb;
    endtask

    task automatic add(input logic [2:0] req, input logic [2:0] lock, input logic sb,
                       input logic rr, input logic ce, input owner_t own,
                       input logic [2:0] busy, input logic sreq, input logic slock);
        vec_t v;
        v.req = req; v.lock = lock; v.sb = sb; v.rr = rr; v.ce = ce;
        v.own = own; v.busy = busy; v.sreq = sreq; v.slock = slock;
        vecs.push_back(v);
    endtask

    initial begin
        logic [2:0]  g;
        logic [31:0] ea;
        vec_t        v;

        // Round robin from reset pointer 2: 0,1,2,0,1,2 with no bubbles.
        for (int r = 0; r < 2; r++) begin
            add(3'b111, 3'b000, 1'b0, 1'b1, 1'b1, 2'd0, 3'b110, 1'b1, 1'b0);
            add(3'b111, 3'b000, 1'b0, 1'b1, 1'b1, 2'd1, 3'b101, 1'b1, 1'b0);
            add(3'b111, 3'b000, 1'b0, 1'b1, 1'b1, 2'd2, 3'b011, 1'b1, 1'b0);
        end
        // Fixed priority: M0 keeps winning, M1 the edge after M0 drops REQ.
        for (int r = 0; r < 3; r++)
            add(3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 2'd0, 3'b110, 1'b1, 1'b0);
        add(3'b110, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1, 3'b100, 1'b1, 1'b0);
        add(3'b110, 3'b000, 1'b1, 1'b0, 1'b1, 2'd1, 3'b110, 1'b1, 1'b0);
        add(3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 3'b101, 1'b1, 1'b0);
        add(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, OWN_NONE, 3'b000, 1'b0, 1'b0);
        // Locked read then unlocked write by M0 with M1 waiting.
        add(3'b011, 3'b001, 1'b0, 1'b1, 1'b1, 2'd0, 3'b010, 1'b1, 1'b1);
        add(3'b011, 3'b001, 1'b0, 1'b1, 1'b1, 2'd0, 3'b010, 1'b1, 1'b1);
        add(3'b010, 3'b001, 1'b0, 1'b1, 1'b1, 2'd0, 3'b010, 1'b0, 1'b1);
        add(3'b011, 3'b000, 1'b1, 1'b1, 1'b1, 2'd0, 3'b011, 1'b1, 1'b0);
        add(3'b011, 3'b000, 1'b0, 1'b1, 1'b1, 2'd1, 3'b001, 1'b1, 1'b0);
        // M2 locked burst, M0 pending: forced release after 4 completions.
        add(3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000, 1'b1, 1'b1);
        for (int r = 0; r < 3; r++)
            add(3'b101, 3'b100, 1'b0, 1'b0, 1'b1, 2'd2, 3'b001, 1'b1, 1'b1);
        add(3'b101, 3'b100, 1'b0, 1'b0, 1'b1, 2'd0, 3'b100, 1'b1, 1'b0);
        // M2 resumes; its count restarted, so 4 more before the next release.
        add(3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000, 1'b1, 1'b1);
        for (int r = 0; r < 3; r++)
            add(3'b101, 3'b100, 1'b0, 1'b0, 1'b1, 2'd2, 3'b001, 1'b1, 1'b1);
        add(3'b101, 3'b100, 1'b0, 1'b0, 1'b1, 2'd0, 3'b100, 1'b1, 1'b0);
        add(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, OWN_NONE, 3'b000, 1'b0, 1'b0);
        // Long lock with nobody else pending keeps the bus; count saturates.
        for (int r = 0; r < 6; r++)
            add(3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000, 1'b1, 1'b1);
        add(3'b101, 3'b100, 1'b0, 1'b0, 1'b1, 2'd0, 3'b100, 1'b1, 1'b0);
        add(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, OWN_NONE, 3'b000, 1'b0, 1'b0);

        for (int i = 0; i < NUM_MASTERS; i++) begin
            bus.m_a[i]  = a_tab[i];
            bus.m_do[i] = do_tab[i];
            bus.m_ba[i] = 4'(i + 1);
        end
        bus.m_we = 3'b101;
        bus.s_di = 32'hCAFE_F00D;
        set_in(3'b000, 3'b000, 1'b0);

        // Reset state.
        rst_n = 1'b0;
        tick;
        tick;
        chk("rst owner", 32'(owner), 32'(OWN_NONE));
        chk("rst state", 32'(state), 32'(ST_IDLE));
        chk("rst gnt", 32'(bus.m_gnt), 32'h0);
        chk("rst s_req", 32'(bus.s_req), 32'h0);
        chk("rst s_a", bus.s_a, 32'h0);
        chk("rst s_do", bus.s_do, 32'h0);
        chk("rst s_ba", 32'(bus.s_ba), 32'h0);
        chk("rst s_we", 32'(bus.s_we), 32'h0);
        chk("rst s_lock", 32'(bus.s_lock), 32'h0);
        bus.m_req = 3'b101;
        #1;
        chk("rst busy=req", 32'(bus.m_busy), 32'h5);
        chk("m1 di", bus.m_di[1], 32'hCAFE_F00D);
        bus.m_req = 3'b000;
        rst_n = 1'b1;
        tick;
        chk("idle owner", 32'(owner), 32'(OWN_NONE));

        foreach (vecs[k]) begin
            v     = vecs[k];
            ce_r  = v.ce;
            rr_en = v.rr;
            set_in(v.req, v.lock, v.sb);
            exp_q.push_back((v.own == OWN_NONE) ? 32'h0 : a_tab[v.own]);
            tick;
            g  = (v.own == OWN_NONE) ? 3'b000 : 3'(1 << v.own);
            ea = exp_q.pop_front();
            chk($sformatf("row%0d owner", k), 32'(owner), 32'(v.own));
            chk($sformatf("row%0d gnt", k), 32'(bus.m_gnt), 32'(g));
            chk($sformatf("row%0d busy", k), 32'(bus.m_busy), 32'(v.busy));
            chk($sformatf("row%0d s_req", k), 32'(bus.s_req), 32'(v.sreq));
            chk($sformatf("row%0d s_lock", k), 32'(bus.s_lock), 32'(v.slock));
            chk($sformatf("row%0d s_a", k), bus.s_a, ea);
            chk($sformatf("row%0d s_do", k), bus.s_do,
                (v.own == OWN_NONE) ? 32'h0 : do_tab[v.own]);
        end

        // M1 write held for three wait periods.
        ce_r  = 1'b1;
        rr_en = 1'b0;
        bus.m_a[1]  = 32'hFFFF_FF80;
        bus.m_do[1] = 32'h1234_5678;
        bus.m_ba[1] = 4'hF;
        bus.m_we[1] = 1'b1;
        set_in(3'b010, 3'b000, 1'b1);
        tick;
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("ws%0d owner", p), 32'(owner), 32'd1);
            chk($sformatf("ws%0d s_a", p), bus.s_a, 32'hFFFF_FF80);
            chk($sformatf("ws%0d s_do", p), bus.s_do, 32'h1234_5678);
            chk($sformatf("ws%0d s_we", p), 32'(bus.s_we), 32'd1);
            chk($sformatf("ws%0d s_ba", p), 32'(bus.s_ba), 32'hF);
            chk($sformatf("ws%0d m1_busy", p), 32'(bus.m_busy[1]), 32'd1);
            if (p < 2) tick;
        end
        bus.s_busy = 1'b0;
        #1;
        chk("ws m1_busy follows", 32'(bus.m_busy[1]), 32'd0);
        tick;
        chk("ws done owner", 32'(owner), 32'd1);
        bus.m_req = 3'b000;
        tick;
        chk("ws release owner", 32'(owner), 32'(OWN_NONE));

        // Reset in the middle of an M1 transfer, with CE_R low.
        set_in(3'b010, 3'b000, 1'b1);
        tick;
        chk("mid owner", 32'(owner), 32'd1);
        rst_n = 1'b0;
        ce_r  = 1'b0;
        tick;
        chk("mid rst owner", 32'(owner), 32'(OWN_NONE));
        chk("mid rst s_req", 32'(bus.s_req), 32'd0);
        chk("mid rst m1_busy", 32'(bus.m_busy[1]), 32'd1);
        chk("mid rst s_a", bus.s_a, 32'h0);
        rst_n = 1'b1;
        ce_r  = 1'b1;
        tick;
        chk("regrant owner", 32'(owner), 32'd1);
        chk("regrant gnt", 32'(bus.m_gnt), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
